// File: rtl/lion_gate_pkg.sv
// Shared types and constants for the lion gate occupancy counter.
// Holds the passage FSM state encoding and the debounce lower bound.
package lion_gate_pkg;

  localparam int MIN_DEBOUNCE_CYCLES = 1;

  typedef enum logic [2:0] {
    IDLE,
    IN_A,
    IN_AB,
    IN_B,
    OUT_B,
    OUT_AB,
    OUT_A,
    ERR
  } gate_state_t;

endpackage

// File: rtl/gate_debounce.sv
// Two-flop synchronizer followed by a debouncer for one raw light barrier.
// The debounced level flips only after DEBOUNCE_CYCLES consecutive differing samples.
module gate_debounce
  import lion_gate_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level
);

  // Values below the minimum are clamped so the counter never underflows its target
  localparam int EFF_CYCLES = (DEBOUNCE_CYCLES < MIN_DEBOUNCE_CYCLES) ?
                              MIN_DEBOUNCE_CYCLES : DEBOUNCE_CYCLES;
  localparam int CW = $clog2(EFF_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(EFF_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] stable_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1      <= 1'b0;
      sync2      <= 1'b0;
      level      <= 1'b0;
      stable_cnt <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      if (sync2 != level) begin
        if (stable_cnt == LAST) begin
          level      <= sync2;
          stable_cnt <= '0;
        end else begin
          stable_cnt <= stable_cnt + CW'(1);
        end
      end else begin
        stable_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/lion_gate_counter.sv
// Occupancy counter for a two-barrier gate: debounces both sensors, tracks the
// passage direction with an FSM and counts completed entries and exits.
module lion_gate_counter
  import lion_gate_pkg::*;
#(
  parameter int CNT_W           = 4,
  parameter int CAPACITY        = 15,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             gate_a,
  input  logic             gate_b,
  input  logic             clear,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty,
  output logic             enter_pulse,
  output logic             exit_pulse,
  output logic             overflow,
  output logic             underflow,
  output logic             seq_err
);

  localparam logic [CNT_W-1:0] CAP_VAL = CNT_W'(CAPACITY);

  logic        a_db;
  logic        b_db;
  logic [1:0]  ab;
  gate_state_t state;
  gate_state_t next_state;
  logic        enter_now;
  logic        exit_now;
  logic        err_now;

  gate_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_a (
    .clk(clk), .reset(reset), .raw(gate_a), .level(a_db)
  );

  gate_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_b (
    .clk(clk), .reset(reset), .raw(gate_b), .level(b_db)
  );

  assign ab = {a_db, b_db};

  // Legal moves go one step forward or back along a path; anything else is ERR
  always_comb begin
    next_state = state;
    enter_now  = 1'b0;
    exit_now   = 1'b0;
    err_now    = 1'b0;
    case (state)
      IDLE: case (ab)
        2'b10:   next_state = IN_A;
        2'b01:   next_state = OUT_B;
        2'b11:   begin next_state = ERR; err_now = 1'b1; end
        default: next_state = IDLE;
      endcase
      IN_A: case (ab)
        2'b11:   next_state = IN_AB;
        2'b00:   next_state = IDLE;
        2'b01:   begin next_state = ERR; err_now = 1'b1; end
        default: next_state = IN_A;
      endcase
      IN_AB: case (ab)
        2'b01:   next_state = IN_B;
        2'b10:   next_state = IN_A;
        2'b00:   begin next_state = ERR; err_now = 1'b1; end
        default: next_state = IN_AB;
      endcase
      IN_B: case (ab)
        2'b00:   begin next_state = IDLE; enter_now = 1'b1; end
        2'b11:   next_state = IN_AB;
        2'b10:   begin next_state = ERR; err_now = 1'b1; end
        default: next_state = IN_B;
      endcase
      OUT_B: case (ab)
        2'b11:   next_state = OUT_AB;
        2'b00:   next_state = IDLE;
        2'b10:   begin next_state = ERR; err_now = 1'b1; end
        default: next_state = OUT_B;
      endcase
      OUT_AB: case (ab)
        2'b10:   next_state = OUT_A;
        2'b01:   next_state = OUT_B;
        2'b00:   begin next_state = ERR; err_now = 1'b1; end
        default: next_state = OUT_AB;
      endcase
      OUT_A: case (ab)
        2'b00:   begin next_state = IDLE; exit_now = 1'b1; end
        2'b11:   next_state = OUT_AB;
        2'b01:   begin next_state = ERR; err_now = 1'b1; end
        default: next_state = OUT_A;
      endcase
      default: begin
        if (ab == 2'b00) next_state = IDLE;
        else             next_state = ERR;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      enter_pulse <= 1'b0;
      exit_pulse  <= 1'b0;
      seq_err     <= 1'b0;
    end else begin
      state       <= next_state;
      enter_pulse <= enter_now;
      exit_pulse  <= exit_now;
      seq_err     <= err_now;
    end
  end

  // Clear wins over a coinciding passage; saturation sets the sticky flags
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (enter_now) begin
      if (count == CAP_VAL) overflow <= 1'b1;
      else                  count    <= count + CNT_W'(1);
    end else if (exit_now) begin
      if (count == '0) underflow <= 1'b1;
      else             count     <= count - CNT_W'(1);
    end
  end

  assign full  = (count == CAP_VAL);
  assign empty = (count == '0);

endmodule

// File: tb/tb_lion_gate_counter.sv
// Directed, table-driven bench for lion_gate_counter with default parameters.
// Pulses are tallied on the falling edge and compared as per-passage deltas.
module tb_lion_gate_counter;

  logic       clk = 1'b0;
  logic       reset;
  logic       gate_a;
  logic       gate_b;
  logic       clear;
  logic [3:0] count;
  logic       full;
  logic       empty;
  logic       enter_pulse;
  logic       exit_pulse;
  logic       overflow;
  logic       underflow;
  logic       seq_err;

  int checks = 0;
  int errors = 0;
  int n_enter = 0;
  int n_exit = 0;
  int n_seq = 0;

  typedef enum int {K_ENTRY, K_EXIT, K_ABORT, K_SEQERR, K_CLEAR} kind_t;

  typedef struct {
    kind_t kind;
    int    exp_count;
    int    exp_enter;
    int    exp_exit;
    int    exp_seq;
    int    exp_full;
    int    exp_empty;
    int    exp_ovf;
    int    exp_unf;
  } vec_t;

  vec_t vecs[10];

  lion_gate_counter #(.CNT_W(4), .CAPACITY(15), .DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .gate_a(gate_a), .gate_b(gate_b), .clear(clear),
    .count(count), .full(full), .empty(empty), .enter_pulse(enter_pulse),
    .exit_pulse(exit_pulse), .overflow(overflow), .underflow(underflow),
    .seq_err(seq_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (enter_pulse) n_enter++;
    if (exit_pulse)  n_exit++;
    if (seq_err)     n_seq++;
  end

  task automatic check_output(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic drive(input logic a, input logic b, input int cycles);
    @(negedge clk);
    gate_a = a;
    gate_b = b;
    repeat (cycles - 1) @(negedge clk);
  endtask

  task automatic apply_stimulus(input kind_t kind);
    case (kind)
      K_ENTRY:  begin drive(1, 0, 10); drive(1, 1, 10); drive(0, 1, 10); drive(0, 0, 10); end
      K_EXIT:   begin drive(0, 1, 10); drive(1, 1, 10); drive(1, 0, 10); drive(0, 0, 10); end
      K_ABORT:  begin drive(1, 0, 10); drive(0, 0, 10); end
      K_SEQERR: begin drive(1, 1, 10); drive(0, 0, 10); end
      default: begin
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        repeat (9) @(negedge clk);
      end
    endcase
  endtask

  task automatic check_flags(input string tag, input int c, input int f, input int e,
                             input int o, input int u);
    check_output({tag, ".count"}, int'(count), c);
    check_output({tag, ".full"}, int'(full), f);
    check_output({tag, ".empty"}, int'(empty), e);
    check_output({tag, ".overflow"}, int'(overflow), o);
    check_output({tag, ".underflow"}, int'(underflow), u);
  endtask

  initial begin
    int s_en, s_ex, s_sq, k;
    string tag;

    vecs[0] = '{K_ENTRY,  1, 1, 0, 0, 0, 0, 0, 0};
    vecs[1] = '{K_ENTRY,  2, 1, 0, 0, 0, 0, 0, 0};
    vecs[2] = '{K_ENTRY,  3, 1, 0, 0, 0, 0, 0, 0};
    vecs[3] = '{K_ABORT,  3, 0, 0, 0, 0, 0, 0, 0};
    vecs[4] = '{K_SEQERR, 3, 0, 0, 1, 0, 0, 0, 0};
    vecs[5] = '{K_EXIT,   2, 0, 1, 0, 0, 0, 0, 0};
    vecs[6] = '{K_EXIT,   1, 0, 1, 0, 0, 0, 0, 0};
    vecs[7] = '{K_EXIT,   0, 0, 1, 0, 0, 1, 0, 0};
    vecs[8] = '{K_EXIT,   0, 0, 1, 0, 0, 1, 0, 1};
    vecs[9] = '{K_CLEAR,  0, 0, 0, 0, 0, 1, 0, 0};

    reset = 1'b1; gate_a = 1'b0; gate_b = 1'b0; clear = 1'b0;
    repeat (3) @(negedge clk);
    check_flags("reset", 0, 0, 1, 0, 0);
    check_output("reset.pulses", int'(enter_pulse) + int'(exit_pulse) + int'(seq_err), 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      s_en = n_enter; s_ex = n_exit; s_sq = n_seq;
      apply_stimulus(vecs[i].kind);
      tag = $sformatf("vec%0d", i);
      check_flags(tag, vecs[i].exp_count, vecs[i].exp_full, vecs[i].exp_empty,
                  vecs[i].exp_ovf, vecs[i].exp_unf);
      check_output({tag, ".enter"}, n_enter - s_en, vecs[i].exp_enter);
      check_output({tag, ".exit"}, n_exit - s_ex, vecs[i].exp_exit);
      check_output({tag, ".seq_err"}, n_seq - s_sq, vecs[i].exp_seq);
    end

    // Fill to capacity, then one entry too many
    for (int i = 0; i < 15; i++) apply_stimulus(K_ENTRY);
    check_flags("fill", 15, 1, 0, 0, 0);
    s_en = n_enter;
    apply_stimulus(K_ENTRY);
    check_flags("over", 15, 1, 0, 1, 0);
    check_output("over.enter", n_enter - s_en, 1);
    apply_stimulus(K_CLEAR);
    check_flags("clear_after_over", 0, 0, 1, 0, 0);

    // Latency from the raw 00 edge to enter_pulse: 2 + 4 + 1
    drive(1, 0, 10); drive(1, 1, 10); drive(0, 1, 10);
    @(negedge clk);
    gate_a = 1'b0; gate_b = 1'b0;
    k = 0;
    while (k < 20 && !enter_pulse) begin
      @(negedge clk);
      k++;
    end
    check_output("latency", k, 7);
    check_output("latency.count", int'(count), 1);
    @(negedge clk);
    check_output("pulse_width", int'(enter_pulse), 0);

    // Clear on the very edge an entry completes
    drive(1, 0, 10); drive(1, 1, 10); drive(0, 1, 10);
    @(negedge clk);
    gate_a = 1'b0; gate_b = 1'b0;
    repeat (6) @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check_output("clear_collide.enter_pulse", int'(enter_pulse), 1);
    check_output("clear_collide.count", int'(count), 0);
    repeat (5) @(negedge clk);

    // Three-cycle dropout of gate_a while in OUT_A must not complete the exit
    apply_stimulus(K_ENTRY);
    drive(0, 1, 10); drive(1, 1, 10); drive(1, 0, 10);
    s_ex = n_exit;
    drive(0, 0, 3);
    drive(1, 0, 12);
    check_output("glitch.exit", n_exit - s_ex, 0);
    check_output("glitch.count", int'(count), 1);
    drive(0, 0, 10);
    check_output("glitch_done.exit", n_exit - s_ex, 1);
    check_flags("glitch_done", 0, 0, 1, 0, 0);

    // Reset while in IN_AB discards the passage
    apply_stimulus(K_ENTRY);
    drive(1, 0, 10); drive(1, 1, 10);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_flags("mid_reset", 0, 0, 1, 0, 0);
    s_en = n_enter;
    repeat (11) @(negedge clk);
    drive(0, 1, 10); drive(0, 0, 10);
    check_output("mid_reset.enter", n_enter - s_en, 0);
    check_output("mid_reset.count_after", int'(count), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL timeout: got running, expected finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
